// File: rtl/store_write_buffer.sv
// Write-through store buffer: queues cache stores in a small FIFO, drains them to
// memory over req/ack, and flags refills that overlap a pending store's 8-byte block.
module store_write_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       wr_mode,
    output logic             full,
    output logic             empty,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] chk_addr,
    output logic             raw_hazard,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic [3:0]       mem_byte_en,
    input  logic             mem_ack
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [3:0]       r_be   [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_hit;

    function automatic logic [3:0] byte_en_of(input logic [2:0] mode);
        return (mode == 3'b011 || mode == 3'b101) ? 4'b0001 : 4'b1111;
    endfunction

    // full comes from the registered count only, so a same-cycle pop never frees a slot
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign mem_req = !empty;
    assign w_push  = wr_en && !full;
    assign w_pop   = mem_req && mem_ack;

    assign mem_addr    = r_addr[r_head];
    assign mem_data    = r_data[r_head];
    assign mem_byte_en = r_be[r_head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry payload carries no reset; validity is tracked by head/count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= wr_addr;
            r_data[r_tail] <= wr_data;
            r_be[r_tail]   <= byte_en_of(wr_mode);
        end
    end

    // An entry is live when its distance from head is below count
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] w_off;
        assign w_off    = PW'(g) - r_head;
        assign w_hit[g] = ({1'b0, w_off} < r_count) &&
                          (r_addr[g][WIDTH-1:3] == chk_addr[WIDTH-1:3]);
    end

    assign raw_hazard = chk_en && (|w_hit);

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store_write_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       wr_mode;
    logic             full;
    logic             empty;
    logic             chk_en;
    logic [WIDTH-1:0] chk_addr;
    logic             raw_hazard;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [3:0]       mem_byte_en;
    logic             mem_ack;

    store_write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
        .full(full), .empty(empty),
        .chk_en(chk_en), .chk_addr(chk_addr), .raw_hazard(raw_hazard),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_byte_en(mem_byte_en), .mem_ack(mem_ack)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] d;
        logic [3:0]       be;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] drain_log[$];
    int               vectors = 0;
    int               miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [2:0] m);
        return (m == 3'd3 || m == 3'd5) ? 4'b0001 : 4'b1111;
    endfunction

    function automatic logic model_hazard();
        if (!chk_en) return 1'b0;
        foreach (q[i])
            if (q[i].a[WIDTH-1:3] == chk_addr[WIDTH-1:3]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: a plain queue; push/pop decided from pre-edge occupancy
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            bit do_push, do_pop;
            ent_t e;
            do_push = wr_en && (q.size() < DEPTH);
            do_pop  = mem_ack && (q.size() > 0);
            e.a = wr_addr;
            e.d = wr_data;
            e.be = model_be(wr_mode);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
        chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
        chk("mem_req", {31'b0, mem_req}, {31'b0, q.size() != 0});
        chk("raw_hazard", {31'b0, raw_hazard}, {31'b0, model_hazard()});
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_data", mem_data, q[0].d);
            chk("mem_byte_en", {28'b0, mem_byte_en}, {28'b0, q[0].be});
        end
        if (mem_req && mem_ack && !rst) drain_log.push_back(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 3'b010;
        chk_en = 1'b0; chk_addr = '0; mem_ack = 1'b0;
        #1 rst = 1'b1;
        step(); step();
        chk("reset_empty", {31'b0, empty}, 32'd1);
        chk("reset_full", {31'b0, full}, 32'd0);
        rst = 1'b0;

        // Reset mid-drain
        wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h1; step();
        wr_addr = 32'h44; wr_data = 32'h2; step();
        wr_en = 1'b0;
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        step(); rst = 1'b0; step(); step();
        chk("post_rst_req", {31'b0, mem_req}, 32'd0);

        // Single word store
        mem_ack = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h0000_0104; wr_data = 32'hDEAD_BEEF; wr_mode = 3'b010;
        step();
        wr_en = 1'b0;
        chk("word_req", {31'b0, mem_req}, 32'd1);
        chk("word_addr", mem_addr, 32'h104);
        chk("word_data", mem_data, 32'hDEADBEEF);
        chk("word_be", {28'b0, mem_byte_en}, 32'hF);
        step();
        chk("word_empty", {31'b0, empty}, 32'd1);

        // Byte store
        mem_ack = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h0000_0207; wr_data = 32'h0000_00A5; wr_mode = 3'b011;
        step();
        wr_en = 1'b0;
        chk("byte_be", {28'b0, mem_byte_en}, 32'h1);
        chk("byte_addr", mem_addr, 32'h207);
        chk("byte_data", mem_data, 32'hA5);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("byte_empty", {31'b0, empty}, 32'd1);

        // Fill and backpressure
        drain_log.delete();
        wr_mode = 3'b010;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 32'h10 + 32'(4 * i); wr_data = 32'(i); step();
        end
        chk("fill_full", {31'b0, full}, 32'd1);
        wr_addr = 32'h20; wr_data = 32'd4; step();
        chk("fill_held", {31'b0, full}, 32'd1);
        mem_ack = 1'b1; step();
        mem_ack = 1'b0;
        chk("fill_after_pop", {31'b0, full}, 32'd0);
        step();
        wr_en = 1'b0;
        chk("fill_5th_in", {31'b0, full}, 32'd1);
        mem_ack = 1'b1;
        repeat (4) step();
        mem_ack = 1'b0;
        chk("fill_drained", {31'b0, empty}, 32'd1);
        chk("drain_count", 32'(drain_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < drain_log.size(); i++)
            chk("drain_order", drain_log[i], 32'h10 + 32'(4 * i));

        // RAW hazard
        wr_en = 1'b1; wr_addr = 32'h0000_0104; wr_data = 32'h5; step();
        wr_en = 1'b0;
        chk_en = 1'b1; chk_addr = 32'h100; #1;
        chk("raw_same_blk", {31'b0, raw_hazard}, 32'd1);
        chk_addr = 32'h108; #1;
        chk("raw_next_blk", {31'b0, raw_hazard}, 32'd0);
        chk_en = 1'b0; chk_addr = 32'h100; #1;
        chk("raw_chk_off", {31'b0, raw_hazard}, 32'd0);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk_en = 1'b1; #1;
        chk("raw_after_ack", {31'b0, raw_hazard}, 32'd0);
        chk_en = 1'b0;

        // Wrap-around with simultaneous push and pop
        drain_log.delete();
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 32'h300 + 32'(4 * i); wr_data = 32'h900 + 32'(i); step();
            chk("wrap_not_full", {31'b0, full}, 32'd0);
        end
        wr_en = 1'b0; step();
        chk("wrap_empty", {31'b0, empty}, 32'd1);
        chk("wrap_count", 32'(drain_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < drain_log.size(); i++)
            chk("wrap_order", drain_log[i], 32'h300 + 32'(4 * i));

        // Randomized traffic; the cache holds its store stable while full
        for (int c = 0; c < 3000; c++) begin
            if (!(wr_en && q.size() == DEPTH)) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = 32'($urandom_range(0, 127));
                wr_data = $urandom;
                wr_mode = 3'($urandom_range(0, 7));
            end
            mem_ack  = ($urandom_range(0, 2) == 0);
            chk_en   = 1'($urandom_range(0, 1));
            chk_addr = 32'($urandom_range(0, 127));
            step();
        end
        wr_en = 1'b0; mem_ack = 1'b1; chk_en = 1'b0;
        repeat (DEPTH + 1) step();
        chk("final_empty", {31'b0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
